// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR display demo control slice.
//   db_state_t        : key debouncer states
//   LFSR_DB_CYCLES    : default debounce length in clk cycles
//   LFSR_AUTO_PERIOD  : default auto-run step period in clk cycles
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } db_state_t;

    localparam int LFSR_DB_CYCLES   = 20000;
    localparam int LFSR_AUTO_PERIOD = 1000000;

endpackage

// File: rtl/lfsr_step_ctrl_debounce.sv
// key_debounce: two-flop synchroniser plus debounce FSM for one raw key.
// A press is accepted once the synchronised level has been high for
// DB_CYCLES consecutive checks after leaving IDLE; a release must likewise
// hold low before another press can be accepted. Exactly one press pulse is
// produced per accepted press, never while the key is held.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   key_raw in  raw asynchronous key level (active-high)
//   press   out registered one-cycle pulse on an accepted press
module key_debounce
    import lfsr_pkg::*;
#(
    parameter int DB_CYCLES = LFSR_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic          key_sync;
    db_state_t     state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          press_reg, press_next;

    assign key_sync = sync_reg[1];
    assign press    = press_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= 2'b00;
            state_reg <= IDLE;
            count_reg <= '0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_raw};
            state_reg <= state_next;
            count_reg <= count_next;
            press_reg <= press_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        press_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (key_sync) begin
                    state_next = PRESS_CHK;
                    count_next = '0;
                end
            end
            PRESS_CHK: begin
                // A drop back to 0 always abandons the check, even on the last count.
                if (!key_sync) begin
                    state_next = IDLE;
                end else if (count_reg == LAST) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            PRESSED: begin
                if (!key_sync) begin
                    state_next = REL_CHK;
                    count_next = '0;
                end
            end
            REL_CHK: begin
                // Bounce back high during release: still pressed, no new pulse.
                if (key_sync) begin
                    state_next = PRESSED;
                end else if (count_reg == LAST) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// lfsr_step_ctrl: turns raw board keys into clean one-cycle load_en/shift_en
// strobes for the 8-bit LFSR shifter and counts the steps taken.
// Optional auto-run timer is compiled in when LFSR_AUTO_RUN_EN is defined.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   btn_step in  raw key: request one LFSR step
//   btn_load in  raw key: request load of din
//   run_sw   in  raw switch: auto-run enable (unused without LFSR_AUTO_RUN_EN)
//   shift_en out one-cycle strobe: advance LFSR one step
//   load_en  out one-cycle strobe: load din into shifter
//   running  out high while auto-run is active
//   step_cnt out steps since last load/reset (wraps)
module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int DB_CYCLES   = LFSR_DB_CYCLES,
    parameter int AUTO_PERIOD = LFSR_AUTO_PERIOD,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_step,
    input  logic                 btn_load,
    input  logic                 run_sw,
    output logic                 shift_en,
    output logic                 load_en,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] step_cnt
);

    // Bit 0 = step key, bit 1 = load key.
    logic [1:0] key_raw;
    logic [1:0] key_press;
    logic       step_req;

    assign key_raw = {btn_load, btn_step};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .key_raw(key_raw[gi]),
                .press  (key_press[gi])
            );
        end
    endgenerate

`ifdef LFSR_AUTO_RUN_EN
    localparam int TW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;

    logic [1:0]    run_sync_reg;
    logic [TW-1:0] timer_reg, timer_next;
    logic          tick;

    assign running = run_sync_reg[1];
    assign tick    = running && (timer_reg == TW'(AUTO_PERIOD - 1));

    // Timer is held at 0 whenever auto-run is off, so a fresh run always
    // waits a full period and a falling run_sw leaves no trailing tick.
    always_comb begin
        timer_next = timer_reg + 1'b1;
        if (!running || load_en || tick) begin
            timer_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_sync_reg <= 2'b00;
            timer_reg    <= '0;
        end else begin
            run_sync_reg <= {run_sync_reg[0], run_sw};
            timer_reg    <= timer_next;
        end
    end

    // Manual presses are still debounced while running, just not used.
    assign step_req = running ? tick : key_press[0];
`else
    logic unused_inputs;
    assign unused_inputs = run_sw & (AUTO_PERIOD != 0);
    assign running       = 1'b0;
    assign step_req      = key_press[0];
`endif

    // Load has priority; a coincident step is dropped rather than deferred.
    assign load_en  = key_press[1];
    assign shift_en = step_req & ~key_press[1];

    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

    assign step_cnt = cnt_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (load_en) begin
            cnt_next = '0;
        end else if (shift_en) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
module tb_lfsr_step_ctrl;

    localparam int DB = 4;
    localparam int AP = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_step = 1'b0;
    logic          btn_load = 1'b0;
    logic          run_sw = 1'b0;
    logic          shift_en, load_en, running;
    logic [CW-1:0] step_cnt;

    lfsr_step_ctrl #(
        .DB_CYCLES  (DB),
        .AUTO_PERIOD(AP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_step(btn_step),
        .btn_load(btn_load),
        .run_sw  (run_sw),
        .shift_en(shift_en),
        .load_en (load_en),
        .running (running),
        .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;

    // Reference model: keys delayed two samples, then a level is accepted
    // once it differs from the accepted level for DB+1 consecutive samples.
    bit m_d1[2], m_d2[2], m_lvl[2];
    int m_run[2];
    bit m_shift, m_load, m_running, m_rd1;
    int m_cnt, m_since;

    int shift_seen, load_seen, last_shift_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_no);
    endtask

    task automatic model_edge(input bit r, input bit bs, input bit bl, input bit rs);
        bit raw[2];
        bit pulse[2];
        bit in_s;
        bit step_src;
        raw[0] = bs;
        raw[1] = bl;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                m_d1[k] = 0; m_d2[k] = 0; m_lvl[k] = 0; m_run[k] = 0;
            end
            m_shift = 0; m_load = 0; m_running = 0; m_rd1 = 0;
            m_cnt = 0; m_since = 0;
            return;
        end
        // Registers driven by the strobes of the cycle just ended.
        if (m_load) m_cnt = 0;
        else if (m_shift) m_cnt = (m_cnt + 1) % (1 << CW);
        if (!m_running || m_load) m_since = 0;
        else m_since++;
        m_running = m_rd1;
        m_rd1 = rs;
        for (int k = 0; k < 2; k++) begin
            in_s = m_d2[k];
            m_d2[k] = m_d1[k];
            m_d1[k] = raw[k];
            pulse[k] = 0;
            if (in_s != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == DB + 1) begin
                    m_lvl[k] = in_s;
                    m_run[k] = 0;
                    pulse[k] = in_s;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_load = pulse[1];
        step_src = pulse[0];
`ifdef LFSR_AUTO_RUN_EN
        if (m_running) step_src = ((m_since % AP) == AP - 1);
`else
        m_running = 0;
`endif
        m_shift = step_src && !m_load;
    endtask

    task automatic cyc(input bit r, input bit bs, input bit bl, input bit rs);
        rst = r; btn_step = bs; btn_load = bl; run_sw = rs;
        @(posedge clk);
        edge_no++;
        model_edge(r, bs, bl, rs);
        #1;
        check("shift_en", 32'(shift_en), 32'(m_shift));
        check("load_en", 32'(load_en), 32'(m_load));
        check("running", 32'(running), 32'(m_running));
        check("step_cnt", 32'(step_cnt), 32'(m_cnt));
        if (shift_en) begin shift_seen++; last_shift_edge = edge_no; end
        if (load_en) load_seen++;
    endtask

    task automatic press(input bit bs, input bit bl, input int hi, input int lo);
        for (int i = 0; i < hi; i++) cyc(0, bs, bl, 0);
        for (int i = 0; i < lo; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        int s0, l0, start_edge;
        bit bs, bl;
        logic [6:0] bounce_on;
        logic [5:0] bounce_off;
        bounce_on  = 7'b1111101;
        bounce_off = 6'b000010;

        // Reset
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 1);
        check("reset_cnt", 32'(step_cnt), 32'd0);
        check("reset_strobes", {30'd0, shift_en, load_en}, 32'd0);
        $display("step reset: step_cnt=%0d", step_cnt);

        // 1: clean held press, latency DB+2 from first sampled edge
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        s0 = shift_seen;
        start_edge = edge_no + 1;
        press(1, 0, 20, 10);
        check("t1_count", 32'(shift_seen - s0), 32'd1);
        check("t1_edge", 32'(last_shift_edge), 32'(start_edge + DB + 2));
        check("t1_cnt", 32'(step_cnt), 32'd1);
        $display("step t1: one strobe at edge %0d, step_cnt=%0d", last_shift_edge, step_cnt);

        // 2: glitch shorter than DB cycles
        s0 = shift_seen;
        press(1, 0, 3, 15);
        check("t2_count", 32'(shift_seen - s0), 32'd0);
        check("t2_cnt", 32'(step_cnt), 32'd1);
        $display("step t2: glitch, step_cnt=%0d", step_cnt);

        // 3: bouncy press and release
        s0 = shift_seen;
        for (int i = 0; i < 7; i++) cyc(0, bounce_on[6-i], 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, bounce_off[5-i], 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        check("t3_count", 32'(shift_seen - s0), 32'd1);
        $display("step t3: bounce, step_cnt=%0d", step_cnt);

        // 4: wrap after 256 presses from reset, then load
        cyc(1, 0, 0, 0);
        s0 = shift_seen;
        for (int p = 0; p < 256; p++) press(1, 0, 6, 6);
        check("t4_count", 32'(shift_seen - s0), 32'd256);
        check("t4_wrap", 32'(step_cnt), 32'd0);
        press(1, 0, 6, 6);
        check("t4_after", 32'(step_cnt), 32'd1);
        l0 = load_seen;
        press(0, 1, 6, 6);
        check("t4_load", 32'(load_seen - l0), 32'd1);
        check("t4_cnt", 32'(step_cnt), 32'd0);
        $display("step t4: wrap + load, step_cnt=%0d", step_cnt);

        // 5: both keys on the same edge
        press(1, 0, 6, 6);
        s0 = shift_seen;
        l0 = load_seen;
        press(1, 1, 8, 8);
        check("t5_load", 32'(load_seen - l0), 32'd1);
        check("t5_shift", 32'(shift_seen - s0), 32'd0);
        check("t5_cnt", 32'(step_cnt), 32'd0);
        $display("step t5: simultaneous, step_cnt=%0d", step_cnt);

        // Random bouncy keys against the model
        bs = 0; bl = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) bs = ~bs;
            if ($urandom_range(0, 11) == 0) bl = ~bl;
            cyc(0, bs, bl, 0);
        end
        press(0, 0, 0, 10);
        $display("step random: shifts=%0d loads=%0d step_cnt=%0d", shift_seen, load_seen, step_cnt);

`ifdef LFSR_AUTO_RUN_EN
        // 6: auto-run with manual presses ignored, reset mid-period
        for (int i = 0; i < 60; i++) cyc(0, ($urandom_range(0, 3) != 0), 0, 1);
        check("t6_running", 32'(running), 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        check("t6_rst_running", 32'(running), 32'd0);
        check("t6_rst_cnt", 32'(step_cnt), 32'd0);
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1);
        press(0, 1, 6, 6);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
        check("t6_off", 32'(running), 32'd0);
        $display("step t6: auto-run, step_cnt=%0d", step_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
